timer_snapshot_master: RTL and testbench

//  Slot-interface initiator (master) for the 48-bit timer I/O core. It drives cs/read/write/addr/wr_data
//  and samples rd_data, so a local client gets a coherent 48-bit count with a one-shot request.
//  It reads hi/lo/hi and re-reads while the high word changes, so the low-word carry cannot tear the value.
//  It also issues control-register writes (go/clear) on request.

---
 rtl/timer_snapshot_master.sv | 173 +++++++++++++++++
 tb/tb_timer_snapshot_master.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_snapshot_master.sv
// timer_snapshot_master
//   Slot-interface initiator for a 48-bit timer I/O core. It gives a local client a coherent
//   48-bit count from a single request: the slot is read hi/lo/hi, and the lo/hi pair is re-read
//   while the high word keeps changing, so a carry out of the low word cannot tear the value.
//   It also issues control-register writes (go/clear) on request.
//
// Ports
//   clk, reset        system clock; synchronous active-high reset
//   rd_req            request a 48-bit snapshot (accepted only while ready=1)
//   wr_req            request a control write (accepted only while ready=1, wins over rd_req)
//   wr_go, wr_clear   control bits sampled together with wr_req
//   ready             idle, can accept a request
//   done              one-cycle completion pulse
//   err               with done: snapshot retries exhausted
//   snapshot          last coherent count, held until the next successful read
//   cs, read, write   slot strobes
//   addr, wr_data     slot register address and write data
//   rd_data           slot read data, combinational from addr

module timer_snapshot_master #(
    parameter logic [4:0]  ADDR_LO   = 5'd0,
    parameter logic [4:0]  ADDR_HI   = 5'd1,
    parameter logic [4:0]  ADDR_CTRL = 5'd2,
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd_req,
    input  logic        wr_req,
    input  logic        wr_go,
    input  logic        wr_clear,
    output logic        ready,
    output logic        done,
    output logic        err,
    output logic [47:0] snapshot,
    output logic        cs,
    output logic        read,
    output logic        write,
    output logic [4:0]  addr,
    output logic [31:0] wr_data,
    input  logic [31:0] rd_data
);

    localparam logic [3:0] MaxRetry = 4'(MAX_RETRY);

    typedef enum logic [2:0] {
        StIdle,
        StRdHi1,
        StRdLo,
        StRdHi2,
        StWrCtrl,
        StDone
    } state_e;

    state_e      state;
    logic [3:0]  retry;
    logic [15:0] hi1;
    logic [31:0] lo;
    logic [15:0] hi2;

    // Only the low 16 bits of the hi register carry count bits.
    logic [15:0] rd_hi;
    assign rd_hi = rd_data[15:0];

    // Outputs are registered and loaded with the values belonging to the state being entered,
    // so each output is a pure function of the current state (Moore), apart from the held
    // snapshot/err results.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= StIdle;
            retry    <= 4'd0;
            hi1      <= 16'h0;
            lo       <= 32'h0;
            hi2      <= 16'h0;
            ready    <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
            snapshot <= 48'h0;
            cs       <= 1'b0;
            read     <= 1'b0;
            write    <= 1'b0;
            addr     <= 5'd0;
            wr_data  <= 32'h0;
        end else begin
            unique case (state)
                StIdle: begin
                    // wr_req wins; a simultaneous rd_req is dropped, not queued.
                    if (wr_req) begin
                        state   <= StWrCtrl;
                        ready   <= 1'b0;
                        cs      <= 1'b1;
                        write   <= 1'b1;
                        addr    <= ADDR_CTRL;
                        wr_data <= {30'b0, wr_clear, wr_go};
                    end else if (rd_req) begin
                        state <= StRdHi1;
                        retry <= 4'd0;
                        ready <= 1'b0;
                        cs    <= 1'b1;
                        read  <= 1'b1;
                        addr  <= ADDR_HI;
                    end
                end

                StRdHi1: begin
                    hi1   <= rd_hi;
                    state <= StRdLo;
                    addr  <= ADDR_LO;
                end

                StRdLo: begin
                    lo    <= rd_data;
                    state <= StRdHi2;
                    addr  <= ADDR_HI;
                end

                StRdHi2: begin
                    hi2 <= rd_hi;
                    if (rd_hi != hi1 && retry < MaxRetry) begin
                        // High word moved under us: the new hi becomes the reference and
                        // only the lo/hi pair is re-read.
                        hi1   <= rd_hi;
                        retry <= retry + 4'd1;
                        state <= StRdLo;
                        addr  <= ADDR_LO;
                    end else begin
                        if (rd_hi == hi1) begin
                            snapshot <= {rd_hi, lo};
                            err      <= 1'b0;
                        end else begin
                            err <= 1'b1;
                        end
                        state <= StDone;
                        done  <= 1'b1;
                        cs    <= 1'b0;
                        read  <= 1'b0;
                        addr  <= 5'd0;
                    end
                end

                StWrCtrl: begin
                    state   <= StDone;
                    done    <= 1'b1;
                    err     <= 1'b0;
                    cs      <= 1'b0;
                    write   <= 1'b0;
                    addr    <= 5'd0;
                    wr_data <= 32'h0;
                end

                StDone: begin
                    state <= StIdle;
                    done  <= 1'b0;
                    err   <= 1'b0;
                    ready <= 1'b1;
                end

                default: begin
                    state   <= StIdle;
                    ready   <= 1'b1;
                    done    <= 1'b0;
                    err     <= 1'b0;
                    cs      <= 1'b0;
                    read    <= 1'b0;
                    write   <= 1'b0;
                    addr    <= 5'd0;
                    wr_data <= 32'h0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_timer_snapshot_master.sv
// tb_timer_snapshot_master
//   Self-checking bench for timer_snapshot_master. A timer slot model answers reads from a
//   48-bit count (optionally running, optionally bumping the high word on every hi read).
//   Expected results come from a fixed table and from an access-by-access reference model.

module tb_timer_snapshot_master;

    localparam int MAX_RETRY = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        rd_req, wr_req, wr_go, wr_clear;
    logic        ready, done, err;
    logic [47:0] snapshot;
    logic        cs, read, write;
    logic [4:0]  addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;

    timer_snapshot_master #(
        .ADDR_LO  (5'd0),
        .ADDR_HI  (5'd1),
        .ADDR_CTRL(5'd2),
        .MAX_RETRY(MAX_RETRY)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .rd_req  (rd_req),
        .wr_req  (wr_req),
        .wr_go   (wr_go),
        .wr_clear(wr_clear),
        .ready   (ready),
        .done    (done),
        .err     (err),
        .snapshot(snapshot),
        .cs      (cs),
        .read    (read),
        .write   (write),
        .addr    (addr),
        .wr_data (wr_data),
        .rd_data (rd_data)
    );

    always #5 clk = ~clk;

    // ---------------- timer slot model ----------------
    logic [47:0] tmr_base = 48'h0;  // written by the stimulus
    logic [47:0] tmr_off  = 48'h0;  // advanced on clock edges
    logic        step     = 1'b0;
    logic        bump     = 1'b0;
    logic [47:0] tmr;

    assign tmr = tmr_base + tmr_off;

    always @(posedge clk) begin
        tmr_off <= tmr_off + {47'b0, step}
                   + ((bump && cs && read && addr == 5'd1) ? 48'h1_0000_0000 : 48'h0);
    end

    // Upper half of the hi register is junk so the DUT must ignore it.
    always_comb begin
        rd_data = 32'hBAD0_BAD0;
        if (addr == 5'd0) rd_data = tmr[31:0];
        else if (addr == 5'd1) rd_data = {16'hA5A5, tmr[47:32]};
    end

    // Slot access monitor: {read, write, addr, wr_data}.
    logic [38:0] acc_q[$];
    always @(negedge clk) begin
        if (cs) acc_q.push_back({read, write, addr, wr_data});
    end

    // ---------------- checking ----------------
    int n_vec = 0;
    int n_cmp = 0;
    int n_mis = 0;
    logic [47:0] model_snap = 48'h0;

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        bit          is_wr;
        bit          go;
        bit          clr;
        bit          bump;
        bit          step;
        logic [47:0] base;
        logic [47:0] exp_snap;
        bit          exp_err;
        int          exp_lat;
        int          exp_acc;
    } vec_t;

    // Reference: walk the hi/lo/hi access pattern; the count seen in cycle c after the accept
    // edge is base + step*c, plus 2^32 for every hi read already made when bumping.
    function automatic logic [47:0] val_at(input logic [47:0] base, input bit stp, input bit bmp,
                                           input int c, input int hireads);
        logic [47:0] v;
        v = base + (stp ? 48'(c) : 48'h0);
        if (bmp) v = v + {16'(hireads), 32'h0};
        return v;
    endfunction

    task automatic model_read(inout vec_t v);
        int          c;
        int          hr;
        logic [47:0] x;
        logic [15:0] h1, h2;
        logic [31:0] lo;
        c = 1; hr = 0;
        x = val_at(v.base, v.step, v.bump, c, hr);
        h1 = x[47:32]; hr++; c++;
        v.exp_acc = 1;
        v.exp_err = 1'b1;
        v.exp_snap = model_snap;
        for (int p = 0; p <= MAX_RETRY; p++) begin
            x = val_at(v.base, v.step, v.bump, c, hr);
            lo = x[31:0]; c++;
            x = val_at(v.base, v.step, v.bump, c, hr);
            h2 = x[47:32]; hr++; c++;
            v.exp_acc += 2;
            if (h2 == h1) begin
                v.exp_err = 1'b0;
                v.exp_snap = {h2, lo};
                break;
            end
            h1 = h2;
        end
        v.exp_lat = c;
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    task automatic run_op(input vec_t v);
        int lat;
        bit seen;
        logic [38:0] a;
        logic [38:0] exp_a;
        n_vec++;
        acc_q.delete();
        tmr_base = v.base - tmr_off;
        step = v.step;
        bump = v.bump;
        wr_go = v.go;
        wr_clear = v.clr;
        if (v.is_wr) wr_req = 1'b1;
        else rd_req = 1'b1;
        @(negedge clk);
        wr_req = 1'b0;
        rd_req = 1'b0;
        lat = 0;
        seen = 1'b0;
        for (int j = 1; j <= 40; j++) begin
            if (done) begin
                lat = j;
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("done_seen", 48'(seen), 48'h1);
        if (seen) begin
            check("latency", 48'(lat), 48'(v.exp_lat));
            check("err", 48'(err), 48'(v.exp_err));
            check("snapshot", snapshot, v.exp_snap);
            check("access_count", 48'(acc_q.size()), 48'(v.exp_acc));
            for (int i = 0; i < acc_q.size() && i < v.exp_acc; i++) begin
                a = acc_q[i];
                if (v.is_wr) exp_a = {1'b0, 1'b1, 5'd2, 30'b0, v.clr, v.go};
                else exp_a = {1'b1, 1'b0, ((i % 2 == 0) ? 5'd1 : 5'd0), 32'h0};
                if (!v.is_wr) a[31:0] = 32'h0;
                check(v.is_wr ? "write_access" : "read_access", 48'(a), 48'(exp_a));
            end
        end
        model_snap = v.exp_snap;
        bump = 1'b0;
        @(negedge clk);
        check("done_one_cycle", 48'(done), 48'h0);
        check("ready_after", 48'(ready), 48'h1);
    endtask

    vec_t table_v[7];

    initial begin
        vec_t v;
        logic [31:0] r1, r2;
        int   ndone;

        // Table: {is_wr, go, clr, bump, step, base, exp_snap, exp_err, exp_lat, exp_acc}
        table_v[0] = '{1, 1, 1, 0, 0, 48'h0,              48'h0,              0, 2, 1};
        table_v[1] = '{0, 0, 0, 0, 0, 48'h0012_3456_789A, 48'h0012_3456_789A, 0, 4, 3};
        table_v[2] = '{0, 0, 0, 0, 1, 48'h0007_FFFF_FFFE, 48'h0008_0000_0002, 0, 6, 5};
        table_v[3] = '{0, 0, 0, 1, 0, 48'h0005_0000_0000, 48'h0008_0000_0002, 1, 10, 9};
        table_v[4] = '{1, 0, 1, 0, 0, 48'h0,              48'h0008_0000_0002, 0, 2, 1};
        table_v[5] = '{0, 0, 0, 0, 1, 48'hFFFF_FFFF_FFFF, 48'h0000_0000_0001, 0, 4, 3};
        table_v[6] = '{0, 0, 0, 0, 1, 48'hFFFF_FFFF_FFFE, 48'h0000_0000_0002, 0, 6, 5};

        reset = 1'b1;
        rd_req = 1'b0; wr_req = 1'b0; wr_go = 1'b0; wr_clear = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", 48'(ready), 48'h1);
        check("rst_done", 48'(done), 48'h0);
        check("rst_err", 48'(err), 48'h0);
        check("rst_snapshot", snapshot, 48'h0);
        check("rst_strobes", 48'({cs, read, write}), 48'h0);
        check("rst_addr_data", 48'({addr, wr_data}), 48'h0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) run_op(table_v[i]);

        // rd_req and wr_req together: only the write happens; rd_req held while busy is ignored.
        acc_q.delete();
        rd_req = 1'b1; wr_req = 1'b1; wr_go = 1'b1; wr_clear = 1'b0;
        @(negedge clk);
        wr_req = 1'b0;
        @(negedge clk);
        check("prio_done", 48'(done), 48'h1);
        check("prio_err", 48'(err), 48'h0);
        rd_req = 1'b0;
        ndone = 0;
        repeat (5) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("prio_extra_done", 48'(ndone), 48'h0);
        check("prio_access_count", 48'(acc_q.size()), 48'h1);
        if (acc_q.size() > 0)
            check("prio_access", 48'(acc_q[0]), 48'({1'b0, 1'b1, 5'd2, 32'h1}));
        check("prio_snapshot", snapshot, model_snap);
        n_vec++;

        // Reset while in RD_LO abandons the read.
        tmr_base = 48'h0001_2345_6789 - tmr_off;
        step = 1'b0;
        rd_req = 1'b1;
        @(negedge clk);
        rd_req = 1'b0;
        @(negedge clk);
        check("mid_in_rd_lo", 48'({read, addr}), 48'({1'b1, 5'd0}));
        reset = 1'b1;
        @(negedge clk);
        check("mid_strobes", 48'({cs, read, write}), 48'h0);
        check("mid_ready", 48'(ready), 48'h1);
        check("mid_snapshot", snapshot, 48'h0);
        check("mid_done", 48'(done), 48'h0);
        reset = 1'b0;
        acc_q.delete();
        ndone = 0;
        repeat (5) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("mid_no_done", 48'(ndone), 48'h0);
        check("mid_no_access", 48'(acc_q.size()), 48'h0);
        model_snap = 48'h0;
        n_vec++;

        // Randomised operations checked against the reference model.
        for (int k = 0; k < 30; k++) begin
            r1 = $urandom();
            r2 = $urandom();
            v.is_wr = ($urandom_range(0, 3) == 0);
            v.go = r1[16];
            v.clr = r1[17];
            v.step = r1[18];
            v.bump = ($urandom_range(0, 4) == 0);
            v.base = {r1[15:0], r2};
            if (r1[19]) v.base[31:0] = 32'hFFFF_FFFF - 32'($urandom_range(0, 4));
            if (v.is_wr) begin
                v.bump = 1'b0;
                v.exp_snap = model_snap;
                v.exp_err = 1'b0;
                v.exp_lat = 2;
                v.exp_acc = 1;
            end else begin
                model_read(v);
            end
            run_op(v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
